lstm_cell_update: RTL and testbench

//  Consumer of the gate pre-activation vector A (4*H words, gate order i,f,g,o) produced by vmvmb.

---
 rtl/lstm_cell_update.sv | 131 +++++++++++++
 tb/tb_lstm_cell_update.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/lstm_cell_update.sv
// LSTM cell-state/hidden-state update: one hidden unit per cycle through a
// two-stage pipeline (gate activation, then cell/hidden arithmetic).
module lstm_cell_update #(
  parameter int H    = 100,
  parameter int W    = 32,
  parameter int FRAC = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [4*H-1:0][W-1:0]   A,
  input  logic [H-1:0][W-1:0]     c_prev,
  output logic                    busy,
  output logic                    done,
  output logic [H-1:0][W-1:0]     c_next,
  output logic [H-1:0][W-1:0]     h_next
);
  localparam int IW = (H > 1) ? $clog2(H) : 1;

  localparam logic signed [W-1:0] ONE     = W'(1) << FRAC;
  localparam logic signed [W-1:0] NEG_ONE = -ONE;
  localparam logic signed [W:0]   ONE_X   = (W+1)'(1) << FRAC;
  localparam logic signed [W:0]   HALF    = (W+1)'(1) << (FRAC-1);
  localparam logic signed [2*W:0] SMAX    = {{(W+2){1'b0}}, {(W-1){1'b1}}};
  localparam logic signed [2*W:0] SMIN    = {{(W+2){1'b1}}, {(W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  function automatic logic signed [W-1:0] hsig(input logic signed [W-1:0] x);
    logic signed [W:0] t;
    t = ((W+1)'(x) >>> 2) + HALF;
    if (t[W]) return '0;
    if (t > ONE_X) return ONE;
    return t[W-1:0];
  endfunction

  function automatic logic signed [W-1:0] htanh(input logic signed [W-1:0] x);
    if (x > ONE) return ONE;
    if (x < NEG_ONE) return NEG_ONE;
    return x;
  endfunction

  function automatic logic signed [W-1:0] sat(input logic signed [2*W:0] v);
    if (v > SMAX) return SMAX[W-1:0];
    if (v < SMIN) return SMIN[W-1:0];
    return v[W-1:0];
  endfunction

  state_t                state;
  logic [IW-1:0]         idx;
  logic [IW-1:0]         s1_idx;
  logic                  vld_pipe;
  logic signed [W-1:0]   s1_i, s1_f, s1_g, s1_o, s1_c;

  // View A as four gate banks so gate k of unit j is ag[k][j].
  logic [3:0][H-1:0][W-1:0] ag;
  assign ag = A;

  logic signed [W-1:0] gi, gf, gg, go, cp;
  always_comb begin
    gi = hsig(ag[0][idx]);
    gf = hsig(ag[1][idx]);
    gg = htanh(ag[2][idx]);
    go = hsig(ag[3][idx]);
    cp = c_prev[idx];
  end

  logic signed [2*W-1:0] pf, pi, po;
  logic signed [2*W:0]   sum, hsh;
  logic signed [W-1:0]   c_new, h_new;
  always_comb begin
    pf    = (2*W)'(s1_f) * (2*W)'(s1_c);
    pi    = (2*W)'(s1_i) * (2*W)'(s1_g);
    sum   = (2*W+1)'(pf) + (2*W+1)'(pi);
    c_new = sat(sum >>> FRAC);
    po    = (2*W)'(s1_o) * (2*W)'(htanh(c_new));
    hsh   = (2*W+1)'(po) >>> FRAC;
    h_new = sat(hsh);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      idx      <= '0;
      s1_idx   <= '0;
      vld_pipe <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      s1_i     <= '0;
      s1_f     <= '0;
      s1_g     <= '0;
      s1_o     <= '0;
      s1_c     <= '0;
      c_next   <= '0;
      h_next   <= '0;
    end else begin
      done     <= 1'b0;
      vld_pipe <= (state == RUN);
      case (state)
        IDLE: begin
          // A start coinciding with the done pulse is dropped.
          if (start && !done) begin
            state <= RUN;
            idx   <= '0;
            busy  <= 1'b1;
          end
        end
        RUN: begin
          s1_i   <= gi;
          s1_f   <= gf;
          s1_g   <= gg;
          s1_o   <= go;
          s1_c   <= cp;
          s1_idx <= idx;
          if (idx == IW'(H-1)) state <= DRAIN;
          else                 idx   <= idx + 1'b1;
        end
        DRAIN: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b1;
        end
        default: state <= IDLE;
      endcase
      if (vld_pipe) begin
        c_next[s1_idx] <= c_new;
        h_next[s1_idx] <= h_new;
      end
    end
  end
endmodule

// File: tb/tb_lstm_cell_update.sv
// Directed bench for lstm_cell_update: timing of busy/done, arithmetic corner
// cases, ignored starts and mid-run reset.
module tb_lstm_cell_update;
  localparam int H = 100, W = 32, FRAC = 16;

  logic                  clk = 1'b0;
  logic                  rst, start;
  logic [4*H-1:0][W-1:0] A;
  logic [H-1:0][W-1:0]   c_prev, c_next, h_next;
  logic                  busy, done;
  int                    n_chk = 0, n_fail = 0;

  always #5 clk = ~clk;

  lstm_cell_update #(.H(H), .W(W), .FRAC(FRAC)) dut (
    .clk(clk), .rst(rst), .start(start), .A(A), .c_prev(c_prev),
    .busy(busy), .done(done), .c_next(c_next), .h_next(h_next)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_run();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic load_vectors();
    A = '0;
    c_prev = '0;
    A[5] = 32'd524288; A[105] = -32'sd524288; A[205] = 32'd32768; A[305] = 32'd524288;
    c_prev[5] = 32'd100000;
    A[0] = 32'd524288; A[100] = 32'd524288; A[200] = 32'd65536; A[300] = 32'd524288;
    c_prev[0] = 32'h7FFF0000;
    A[1] = 32'd524288; A[101] = 32'd524288; A[201] = -32'sd65536; A[301] = 32'd524288;
    c_prev[1] = -32'sh7FFF0000;
  endtask

  task automatic test_reset();
    start = 1'b0; A = '0; c_prev = '0;
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    n_chk++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_fail++; $display("FAIL reset_ctrl: busy=%b done=%b expected 0 0", busy, done);
    end
    n_chk++;
    if (c_next !== '0 || h_next !== '0) begin
      n_fail++; $display("FAIL reset_arrays: c_next[0]=%0h h_next[0]=%0h expected all zero", c_next[0], h_next[0]);
    end
  endtask

  task automatic test_vectors();
    load_vectors();
    start_run();
    repeat (H+1) tick();
    n_chk++;
    if (done !== 1'b1) begin n_fail++; $display("FAIL vec_done: got %b expected 1", done); end
    n_chk++;
    if (c_next[5] !== 32'd32768 || h_next[5] !== 32'd32768) begin
      n_fail++; $display("FAIL unit5: c=%0d h=%0d expected 32768 32768", $signed(c_next[5]), $signed(h_next[5]));
    end
    n_chk++;
    if (c_next[0] !== 32'h7FFFFFFF || h_next[0] !== 32'd65536) begin
      n_fail++; $display("FAIL unit0_satpos: c=%h h=%0d expected 7fffffff 65536", c_next[0], $signed(h_next[0]));
    end
    n_chk++;
    if (c_next[1] !== 32'h80000000 || h_next[1] !== 32'hFFFF0000) begin
      n_fail++; $display("FAIL unit1_satneg: c=%h h=%h expected 80000000 ffff0000", c_next[1], h_next[1]);
    end
    n_chk++;
    if (c_next[2] !== 32'd0 || h_next[99] !== 32'd0) begin
      n_fail++; $display("FAIL unit_zero: c2=%0d h99=%0d expected 0 0", c_next[2], h_next[99]);
    end
    tick();
  endtask

  task automatic test_zero();
    A = '0; c_prev = '0;
    start_run();
    for (int n = 1; n <= H+1; n++) begin
      tick();
      n_chk++;
      if (done !== 1'(n == H+1) || busy !== 1'(n <= H)) begin
        n_fail++; $display("FAIL zero_timing edge %0d: done=%b busy=%b expected %b %b", n, done, busy, n == H+1, n <= H);
      end
      if (n == 2) begin
        n_chk++;
        if (c_next[0] !== 32'd0 || c_next[5] !== 32'd32768) begin
          n_fail++; $display("FAIL partial_hold: c0=%0d c5=%0d expected 0 32768", c_next[0], c_next[5]);
        end
      end
    end
    tick();
    n_chk++;
    if (done !== 1'b0) begin n_fail++; $display("FAIL done_pulse_width: got %b expected 0", done); end
    n_chk++;
    if (c_next !== '0 || h_next !== '0) begin
      n_fail++; $display("FAIL zero_arrays: c0=%0h h0=%0h expected all zero", c_next[0], h_next[0]);
    end
  endtask

  task automatic test_restart();
    int n;
    load_vectors();
    start_run();
    for (int e = 1; e <= H+1; e++) begin
      tick();
      if (e == 39) start = 1'b1;
      if (e == 40) start = 1'b0;
      n_chk++;
      if (done !== 1'(e == H+1)) begin
        n_fail++; $display("FAIL restart_ignored edge %0d: done=%b expected %b", e, done, e == H+1);
      end
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    n_chk++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL start_during_done: busy=%b expected 0", busy); end
    start_run();
    n = 0;
    for (int e = 1; e <= 200; e++) begin
      tick();
      if (done === 1'b1) begin n = e; break; end
    end
    n_chk++;
    if (n != H+1) begin n_fail++; $display("FAIL second_run_latency: done after %0d edges expected %0d", n, H+1); end
  endtask

  task automatic test_mid_reset();
    bit saw_done;
    load_vectors();
    start_run();
    repeat (48) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_chk++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_fail++; $display("FAIL midreset_ctrl: busy=%b done=%b expected 0 0", busy, done);
    end
    n_chk++;
    if (c_next !== '0 || h_next !== '0) begin
      n_fail++; $display("FAIL midreset_arrays: c0=%0h h5=%0h expected all zero", c_next[0], h_next[5]);
    end
    saw_done = 1'b0;
    repeat (110) begin tick(); if (done !== 1'b0) saw_done = 1'b1; end
    n_chk++;
    if (saw_done) begin n_fail++; $display("FAIL midreset_nodone: got done pulse expected none"); end
    start_run();
    repeat (H+1) tick();
    n_chk++;
    if (done !== 1'b1 || c_next[5] !== 32'd32768 || h_next[0] !== 32'd65536) begin
      n_fail++; $display("FAIL post_reset_run: done=%b c5=%0d h0=%0d expected 1 32768 65536", done, c_next[5], h_next[0]);
    end
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_zero();
    test_restart();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
